// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants, the
// NOP word used as the idle instruction, redirect-kind encodings and the
// fetch FSM state encoding.
package fetch_pkg;

  // 5-bit major opcodes (instruction bits [31:27])
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b10010;

  // NOP opcode in the top field, all operands zero -> 32'h9000_0000
  localparam logic [31:0] NOP_WORD = {OP_NOP, 27'd0};

  typedef enum logic [1:0] {
    REDIR_JUMP  = 2'b00,
    REDIR_CALL  = 2'b01,
    REDIR_RET   = 2'b10,
    REDIR_JUMP2 = 2'b11   // reserved encoding, behaves as a jump
  } redir_kind_e;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,  // request outstanding for pc
    ST_FULL = 2'b01,  // buffer holds an instruction for decode
    ST_DROP = 2'b10   // waiting out a stale request after a redirect
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Circular return-address LIFO.
//   clk_i/rst_ni : clock, async active-low reset (stack empty)
//   push_i/data_i: push data_i; when full the oldest entry is overwritten
//   pop_i        : drop the top entry (ignored when empty)
//   top_o        : current top entry
//   empty_o/full_o: occupancy status
// Push has priority if push_i and pop_i are both asserted.
module return_stack
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ptr_q;      // index of the current top entry
  logic [AW-1:0] ptr_inc;
  logic [CW-1:0] cnt_q;

  assign ptr_inc = ptr_q + AW'(1);
  assign top_o   = mem_q[ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

  // With DEPTH a power of two, the slot above the top is also the oldest
  // slot once full, so a push while full naturally overwrites the oldest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_inc] <= data_i;
      ptr_q          <= ptr_inc;
      if (!full_o) cnt_q <= cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - AW'(1);
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
//   clk, reset (async active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata : req/ack instruction memory port
//   instr/instr_pc/instr_valid/instr_ready : one-entry buffer to decode
//   redir_valid/kind/target/link           : control-transfer redirects
//   ras_overflow/ras_underflow             : sticky return-stack error flags
// All outputs are registered. A redirect beats everything else in any state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_target,
  input  logic [31:0] redir_link,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         vld_q, vld_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  logic         ack;
  logic         is_call, is_ret;
  logic         ras_push, ras_pop, ras_empty, ras_full;
  logic [31:0]  ras_top;
  logic [31:0]  redir_pc;

  // An ack is only meaningful against a request we are actually driving.
  assign ack     = imem_ack & req_q;
  assign is_call = redir_valid && (redir_kind_e'(redir_kind) == REDIR_CALL);
  assign is_ret  = redir_valid && (redir_kind_e'(redir_kind) == REDIR_RET);

  assign ras_push = is_call;
  assign ras_pop  = is_ret && !ras_empty;

  // Ret with an empty stack falls back to the supplied target.
  assign redir_pc = align4((is_ret && !ras_empty) ? ras_top : redir_target);

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (32)
  ) u_ras (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (redir_link),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_REQ: begin
        if (redir_valid) begin
          pc_d    = redir_pc;
          vld_d   = 1'b0;
          // If the in-flight word lands this cycle it is simply discarded;
          // otherwise the stale request still has to be drained.
          state_d = ack ? ST_REQ : ST_DROP;
        end else if (ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (redir_valid) begin
          pc_d    = redir_pc;
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end else if (instr_ready) begin
          vld_d   = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redir_valid) begin
          pc_d = redir_pc;
        end else if (ack) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // DROP keeps presenting the stale address until memory acks it.
    req_d  = (state_d != ST_FULL);
    addr_d = (state_d == ST_REQ) ? pc_d : addr_q;
    ovf_d  = ovf_q | (ras_push & ras_full);
    unf_d  = unf_q | (is_ret & ras_empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC_A;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC_A;
      instr_q <= NOP_WORD;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign instr         = instr_q;
  assign instr_pc      = ipc_q;
  assign instr_valid   = vld_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory that
// acks a held request after `lat` extra cycles and returns mkword(addr).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_target;
  logic [31:0] redir_link;
  logic        ras_overflow;
  logic        ras_underflow;

  fetch_unit #(.RESET_PC(32'h0), .RAS_DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redir_valid   (redir_valid),
    .redir_kind    (redir_kind),
    .redir_target  (redir_target),
    .redir_link    (redir_link),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int mcnt   = 0;
  int cyc    = 0;
  logic [31:0] acc_q[$];   // pcs accepted by decode
  logic [31:0] acc_w[$];   // words accepted by decode
  int          acc_c[$];   // cycle of each acceptance
  logic [31:0] ack_q[$];   // addresses acked by memory

  function automatic logic [31:0] mkword(input logic [31:0] a);
    return {8'hC3, a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes seen before the edge, then update memory model.
  task automatic tick();
    if (reset && instr_valid && instr_ready) begin
      acc_q.push_back(instr_pc);
      acc_w.push_back(instr);
      acc_c.push_back(cyc);
    end
    if (reset && imem_req && imem_ack) ack_q.push_back(imem_addr);
    @(posedge clk);
    #1;
    cyc++;
    redir_valid = 1'b0;
    if (!reset || imem_ack) begin
      imem_ack = 1'b0;
      mcnt     = 0;
    end else if (imem_req) begin
      if (mcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mkword(imem_addr);
      end else begin
        mcnt++;
      end
    end
  endtask

  task automatic redir(input logic [1:0] k, input logic [31:0] t, input logic [31:0] l);
    redir_valid  = 1'b1;
    redir_kind   = k;
    redir_target = t;
    redir_link   = l;
    tick();
  endtask

  task automatic wait_acc(input int n, input string tag);
    int b;
    b = 0;
    while (acc_q.size() < n && b < 80) begin
      tick();
      b++;
    end
    if (acc_q.size() < n) chk({tag, "_timeout"}, acc_q.size(), n);
  endtask

  task automatic clr();
    acc_q.delete();
    acc_w.delete();
    acc_c.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    imem_ack = 1'b0;
    mcnt     = 0;
    tick();
    tick();
    chk("rst_req",   imem_req,      0);
    chk("rst_addr",  imem_addr,     0);
    chk("rst_instr", instr,         32'h9000_0000);
    chk("rst_ipc",   instr_pc,      0);
    chk("rst_vld",   instr_valid,   0);
    chk("rst_ovf",   ras_overflow,  0);
    chk("rst_unf",   ras_underflow, 0);
    reset = 1'b1;
    clr();
    ack_q.delete();
  endtask

  initial begin
    int b, n;
    logic [31:0] w, p;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    redir_valid = 1'b0; redir_kind = '0; redir_target = '0; redir_link = '0;

    // 1: straight-line fetch, zero-wait memory
    do_reset();
    tick();
    chk("t1_req_rise", imem_req, 1);
    chk("t1_addr0",    imem_addr, 0);
    wait_acc(3, "t1");
    if (acc_q.size() >= 3) begin
      chk("t1_pc0", acc_q[0], 32'h0);
      chk("t1_pc1", acc_q[1], 32'h4);
      chk("t1_pc2", acc_q[2], 32'h8);
      chk("t1_w1",  acc_w[1], mkword(32'h4));
      chk("t1_gap1", acc_c[1] - acc_c[0], 2);
      chk("t1_gap2", acc_c[2] - acc_c[1], 2);
    end
    if (ack_q.size() >= 3) chk("t1_ack2", ack_q[2], 32'h8);

    // 2: decode stall holds the buffer
    instr_ready = 1'b0;
    b = 0;
    while (!instr_valid && b < 20) begin tick(); b++; end
    chk("t2_vld", instr_valid, 1);
    w = instr;
    p = instr_pc;
    chk("t2_word", w, mkword(p));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_vld",   instr_valid, 1);
      chk("t2_hold_instr", instr, w);
      chk("t2_hold_req",   imem_req, 0);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_next_req",  imem_req, 1);
    chk("t2_next_addr", imem_addr, p + 32'd4);

    // 3: redirect while a slow request at 8 is pending
    do_reset();
    wait_acc(1, "t3a");
    lat = 3;
    b = 0;
    while (!(imem_req && imem_addr == 32'h8 && !imem_ack) && b < 40) begin tick(); b++; end
    chk("t3_pending8", imem_addr, 32'h8);
    redir(2'b00, 32'h100, 32'h0);
    chk("t3_drop_req",  imem_req, 1);
    chk("t3_drop_addr", imem_addr, 32'h8);
    chk("t3_drop_vld",  instr_valid, 0);
    clr();
    n = ack_q.size();
    wait_acc(1, "t3b");
    if (acc_q.size() >= 1) begin
      chk("t3_pc",   acc_q[0], 32'h100);
      chk("t3_word", acc_w[0], mkword(32'h100));
    end
    chk("t3_nacks", ack_q.size() >= n + 2, 1);
    if (ack_q.size() >= n + 2) begin
      chk("t3_stale", ack_q[n],     32'h8);
      chk("t3_new",   ack_q[n + 1], 32'h100);
    end

    // 4: call then ret
    lat = 0;
    redir(2'b01, 32'h200, 32'h14);
    clr();
    wait_acc(1, "t4a");
    if (acc_q.size() >= 1) chk("t4_call_pc", acc_q[0], 32'h200);
    redir(2'b10, 32'hDEAD_BEE0, 32'h0);
    clr();
    wait_acc(1, "t4b");
    if (acc_q.size() >= 1) chk("t4_ret_pc", acc_q[0], 32'h14);
    chk("t4_unf", ras_underflow, 0);
    chk("t4_ovf", ras_overflow, 0);

    // 5: overflow then underflow of an 8-deep stack
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      redir(2'b01, 32'h400, i * 16);
      tick();
      if (i == 8) chk("t5_ovf_at8", ras_overflow, 0);
    end
    chk("t5_ovf", ras_overflow, 1);
    chk("t5_unf0", ras_underflow, 0);
    for (int i = 1; i <= 9; i++) begin
      redir(2'b10, 32'h00BE_EF00, 32'h0);
      clr();
      wait_acc(1, "t5");
      if (acc_q.size() >= 1)
        chk($sformatf("t5_ret%0d", i), acc_q[0], (i <= 8) ? (10 - i) * 16 : 32'h00BE_EF00);
      chk($sformatf("t5_unf%0d", i), ras_underflow, (i == 9) ? 1 : 0);
    end

    // 6: pc wrap, alignment, async reset
    redir(2'b11, 32'hFFFF_FFFC, 32'h0);
    clr();
    wait_acc(2, "t6a");
    if (acc_q.size() >= 2) begin
      chk("t6_top",  acc_q[0], 32'hFFFF_FFFC);
      chk("t6_wrap", acc_q[1], 32'h0);
      chk("t6_w",    acc_w[0], 32'hC3FF_FFFC);
    end
    redir(2'b00, 32'h0000_0303, 32'h0);
    clr();
    wait_acc(1, "t6b");
    if (acc_q.size() >= 1) chk("t6_align", acc_q[0], 32'h300);

    lat = 5;
    b = 0;
    while (!(imem_req && !imem_ack) && b < 20) begin tick(); b++; end
    #2;
    reset = 1'b0;
    imem_ack = 1'b0;
    mcnt = 0;
    #1;
    chk("t6_arst_req", imem_req, 0);
    chk("t6_arst_vld", instr_valid, 0);
    tick();
    reset = 1'b1;
    lat = 0;
    instr_ready = 1'b0;
    clr();
    b = 0;
    while (!instr_valid && b < 20) begin tick(); b++; end
    chk("t6_full_pc", instr_pc, 32'h0);
    #2;
    reset = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("t6_arst_vld_full", instr_valid, 0);
    chk("t6_arst_instr",    instr, 32'h9000_0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
